drop_scheduler: RTL and testbench

- Gravity and lock-delay controller for the Tetris playfield.
- Tracks cleared lines, derives the level, and selects the gravity period from a per-level table, with inferno and soft-drop overrides.
- Produces one-cycle `drop_tick` pulses for the piece mover and a one-cycle `lock_req` when a resting piece must be frozen.
- Sequences a piece's life cycle: fall, lock delay, wait for spawn. Sits between the input/playfield logic and the piece-movement datapath.

---
 rtl/drop_scheduler.sv | 135 +++++++++++++
 tb/tb_drop_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/drop_scheduler.sv
// Gravity and lock-delay controller: level-indexed drop period, one-cycle drop_tick and lock_req pulses.
// Pause freezes timers and state; line-count additions are still taken while paused.
module drop_scheduler #(
   parameter logic [31:0] PERIOD_L0       = 32'd25_000_000,
   parameter logic [31:0] PERIOD_L1       = 32'd12_500_000,
   parameter logic [31:0] PERIOD_L2       = 32'd6_250_000,
   parameter logic [31:0] PERIOD_L3       = 32'd5_000_000,
   parameter logic [31:0] PERIOD_L4       = 32'd2_500_000,
   parameter logic [31:0] PERIOD_L5       = 32'd1_250_000,
   parameter logic [31:0] INFERNO_PERIOD  = 32'd5_000_000,
   parameter logic [31:0] SOFT_PERIOD     = 32'd1_250_000,
   parameter logic [31:0] LOCK_CYCLES     = 32'd12_500_000,
   parameter logic [31:0] LINES_PER_LEVEL = 32'd10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pause,
   input  logic        sw_inferno,
   input  logic        soft_drop,
   input  logic        landed,
   input  logic        piece_spawned,
   input  logic        game_over,
   input  logic        lines_valid,
   input  logic [2:0]  lines_cleared,
   output logic        drop_tick,
   output logic        lock_req,
   output logic [2:0]  level,
   output logic [13:0] total_lines,
   output logic [2:0]  state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_LOCK  = 3'd2;
   localparam logic [2:0] S_SPAWN = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;

   logic [31:0] drop_cnt;
   logic [31:0] lock_cnt;
   logic [31:0] base_period;
   logic [31:0] period;
   logic [14:0] line_sum;
   logic [13:0] lines_next;
   logic [31:0] level_raw;
   logic [2:0]  level_next;
   logic        in_game;

   always_comb begin
      base_period = PERIOD_L5;
      case (level)
         3'd0:    base_period = PERIOD_L0;
         3'd1:    base_period = PERIOD_L1;
         3'd2:    base_period = PERIOD_L2;
         3'd3:    base_period = PERIOD_L3;
         3'd4:    base_period = PERIOD_L4;
         default: base_period = PERIOD_L5;
      endcase
      period = sw_inferno ? INFERNO_PERIOD : base_period;
      if (soft_drop && (period > SOFT_PERIOD))
         period = SOFT_PERIOD;
   end

   assign in_game    = (state == S_RUN) || (state == S_LOCK) || (state == S_SPAWN);
   assign line_sum   = {1'b0, total_lines} + {12'd0, lines_cleared};
   assign lines_next = (line_sum > 15'd9999) ? 14'd9999 : line_sum[13:0];
   assign level_raw  = {18'd0, total_lines} / LINES_PER_LEVEL;
   assign level_next = (level_raw > 32'd5) ? 3'd5 : level_raw[2:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_IDLE;
         drop_tick   <= 1'b0;
         lock_req    <= 1'b0;
         level       <= 3'd0;
         total_lines <= 14'd0;
         drop_cnt    <= 32'd0;
         lock_cnt    <= 32'd0;
      end else begin
         drop_tick <= 1'b0;
         lock_req  <= 1'b0;
         level     <= level_next;
         if (lines_valid && in_game)
            total_lines <= lines_next;

         if (!pause) begin
            if (game_over && in_game) begin
               state <= S_OVER;
            end else if (start && ((state == S_IDLE) || (state == S_OVER))) begin
               // Fresh game: these clears override the level/line updates above.
               state       <= S_RUN;
               total_lines <= 14'd0;
               level       <= 3'd0;
               drop_cnt    <= 32'd0;
               lock_cnt    <= 32'd0;
            end else begin
               case (state)
                  S_RUN: begin
                     if (landed) begin
                        state    <= S_LOCK;
                        lock_cnt <= 32'd0;
                     end else if (drop_cnt >= period - 32'd1) begin
                        drop_tick <= 1'b1;
                        drop_cnt  <= 32'd0;
                     end else begin
                        drop_cnt <= drop_cnt + 32'd1;
                     end
                  end
                  S_LOCK: begin
                     if (!landed) begin
                        state    <= S_RUN;
                        drop_cnt <= 32'd0;
                     end else if (lock_cnt >= LOCK_CYCLES - 32'd1) begin
                        state    <= S_SPAWN;
                        lock_req <= 1'b1;
                        lock_cnt <= 32'd0;
                     end else begin
                        lock_cnt <= lock_cnt + 32'd1;
                     end
                  end
                  S_SPAWN: begin
                     if (piece_spawned) begin
                        state    <= S_RUN;
                        drop_cnt <= 32'd0;
                     end
                  end
                  S_IDLE, S_OVER: ;
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler: expected tick/lock cycles are queued ahead and matched by a monitor.
module tb_drop_scheduler;

   logic        clk = 1'b0;
   logic        rst, start, pause, sw_inferno, soft_drop, landed;
   logic        piece_spawned, game_over, lines_valid;
   logic [2:0]  lines_cleared;
   logic        drop_tick, lock_req;
   logic [2:0]  level;
   logic [13:0] total_lines;
   logic [2:0]  state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int tick_q[$];
   int lock_q[$];

   drop_scheduler #(
      .PERIOD_L0(32'd20), .PERIOD_L1(32'd10), .PERIOD_L2(32'd8),
      .PERIOD_L3(32'd6), .PERIOD_L4(32'd4), .PERIOD_L5(32'd2),
      .INFERNO_PERIOD(32'd5), .SOFT_PERIOD(32'd3),
      .LOCK_CYCLES(32'd8), .LINES_PER_LEVEL(32'd10)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause),
      .sw_inferno(sw_inferno), .soft_drop(soft_drop), .landed(landed),
      .piece_spawned(piece_spawned), .game_over(game_over),
      .lines_valid(lines_valid), .lines_cleared(lines_cleared),
      .drop_tick(drop_tick), .lock_req(lock_req), .level(level),
      .total_lines(total_lines), .state(state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic push_ticks(input int base, input int per, input int n);
      for (int i = 1; i <= n; i++) tick_q.push_back(base + per * i);
   endtask

   task automatic chk_reset_vals();
      chk("rst_state", state, 0);
      chk("rst_level", level, 0);
      chk("rst_lines", total_lines, 0);
      chk("rst_tick", drop_tick, 0);
      chk("rst_lock", lock_req, 0);
   endtask

   // Every pulse the DUT emits must match the next queued expected cycle.
   always @(negedge clk) begin
      if (drop_tick === 1'b1) begin
         chk("tick_expected", tick_q.size() > 0, 1);
         if (tick_q.size() > 0) chk("tick_cycle", cyc, tick_q.pop_front());
      end
      if (lock_req === 1'b1) begin
         chk("lock_expected", lock_q.size() > 0, 1);
         if (lock_q.size() > 0) chk("lock_cycle", cyc, lock_q.pop_front());
      end
   end

   initial begin
      int b, t;
      rst = 1'b0; start = 1'b0; pause = 1'b0; sw_inferno = 1'b0; soft_drop = 1'b0;
      landed = 1'b0; piece_spawned = 1'b0; game_over = 1'b0;
      lines_valid = 1'b0; lines_cleared = 3'd0;
      repeat (3) @(negedge clk);
      chk_reset_vals();
      rst = 1'b1;
      @(negedge clk);

      // Level 0 gravity
      start = 1'b1; @(negedge clk); start = 1'b0; b = cyc;
      chk("start_state", state, 1);
      chk("start_level", level, 0);
      push_ticks(b, 20, 3); wait_to(b + 60); t = b + 60;

      // 4+4+2 lines -> level 1
      lines_valid = 1'b1; lines_cleared = 3'd4; @(negedge clk);
      lines_cleared = 3'd4; @(negedge clk);
      lines_cleared = 3'd2; @(negedge clk);
      lines_valid = 1'b0;
      chk("lines_10", total_lines, 10);
      chk("level_lag", level, 0);
      @(negedge clk);
      chk("level_1", level, 1);
      push_ticks(t, 10, 3); wait_to(t + 30); t = t + 30;

      sw_inferno = 1'b1; push_ticks(t, 5, 3); wait_to(t + 15); t = t + 15;
      soft_drop = 1'b1;  push_ticks(t, 3, 3); wait_to(t + 9);  t = t + 9;

      // Full lock delay
      sw_inferno = 1'b0; soft_drop = 1'b0; landed = 1'b1;
      lock_q.push_back(t + 9);
      @(negedge clk);
      chk("lock_enter", state, 2);
      wait_to(t + 9);
      chk("spawn_state", state, 3);
      @(negedge clk); landed = 1'b0; piece_spawned = 1'b1;
      @(negedge clk); piece_spawned = 1'b0; b = cyc;
      chk("respawn_run", state, 1);
      push_ticks(b, 10, 2); wait_to(b + 20); t = b + 20;

      // Lift off after 5 lock cycles, then re-land
      landed = 1'b1; wait_to(t + 5); landed = 1'b0;
      @(negedge clk);
      chk("unland_run", state, 1);
      landed = 1'b1; lock_q.push_back(t + 15);
      wait_to(t + 14);
      chk("relock_hold", state, 2);
      wait_to(t + 15);
      chk("relock_spawn", state, 3);
      @(negedge clk); landed = 1'b0; piece_spawned = 1'b1;
      @(negedge clk); piece_spawned = 1'b0; b = cyc;

      // 50-cycle pause mid-RUN, then mid-LOCK
      tick_q.push_back(b + 60);
      wait_to(b + 4); pause = 1'b1;
      wait_to(b + 30);
      chk("pause_run_state", state, 1);
      wait_to(b + 54); pause = 1'b0;
      wait_to(b + 60); landed = 1'b1; lock_q.push_back(b + 119);
      wait_to(b + 63); pause = 1'b1;
      wait_to(b + 90);
      chk("pause_lock_state", state, 2);
      wait_to(b + 113); pause = 1'b0;
      wait_to(b + 119);
      chk("pause_lock_spawn", state, 3);
      @(negedge clk); landed = 1'b0; piece_spawned = 1'b1;
      @(negedge clk); piece_spawned = 1'b0; b = cyc;

      // Reset in the middle of LOCK
      landed = 1'b1; wait_to(b + 4); rst = 1'b0;
      wait_to(b + 10);
      chk_reset_vals();
      rst = 1'b1; @(negedge clk);

      // Saturation, reached from SPAWN so no gravity ticks interfere
      t = cyc; lock_q.push_back(t + 10);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_to(t + 10);
      chk("sat_spawn", state, 3);
      lines_valid = 1'b1; lines_cleared = 3'd4;
      repeat (2499) @(negedge clk);
      lines_cleared = 3'd2; @(negedge clk);
      lines_valid = 1'b0;
      chk("lines_9998", total_lines, 9998);
      @(negedge clk);
      chk("level_5", level, 5);
      pause = 1'b1; lines_valid = 1'b1; lines_cleared = 3'd4; @(negedge clk);
      lines_valid = 1'b0;
      chk("lines_sat", total_lines, 9999);
      chk("paused_state", state, 3);
      pause = 1'b0;
      @(negedge clk);
      chk("level_sat", level, 5);

      game_over = 1'b1; @(negedge clk); game_over = 1'b0;
      chk("over_state", state, 4);
      lines_valid = 1'b1; lines_cleared = 3'd3; @(negedge clk); lines_valid = 1'b0;
      chk("over_lines_ignored", total_lines, 9999);

      // start beats game_over and drops the simultaneous add
      landed = 1'b0; start = 1'b1; game_over = 1'b1; lines_valid = 1'b1; lines_cleared = 3'd4;
      @(negedge clk);
      start = 1'b0; game_over = 1'b0; lines_valid = 1'b0; b = cyc;
      chk("restart_state", state, 1);
      chk("restart_lines", total_lines, 0);
      chk("restart_level", level, 0);
      push_ticks(b, 20, 1); wait_to(b + 20);
      @(negedge clk);
      chk("ticks_all_seen", tick_q.size(), 0);
      chk("locks_all_seen", lock_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
